seq_detect_sched: RTL and testbench
===================================

# seq_detect_sched

Round-robin scheduler that shares one serial sequence detector (ports `clk`, `rst_n`, `data_in`, `data_out`) between two parallel-word requesters. It accepts a WIDTH-bit word from the granted requester and shifts it MSB-first into the detector, one bit per cycle. It counts the detector's match pulses over that word and returns the count tagged with the requester id. It holds the detector in reset whenever it is not shifting, so every word is detected independently.

## Interface
- `WIDTH`, 8: bits per word, ≥ 2.
- `CNT_W`, 4: width of the match count; the count saturates at 2^CNT_W−1.

- `clk`  in  1  single clock, all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req0_valid` / `req1_valid`  in  1  requester has a word.
- `req0_data` / `req1_data`  in  WIDTH  word to scan.
- `req0_ready` / `req1_ready`  out  1  word accepted this cycle when valid & ready.
- `det_rst_n`  out  1  detector reset, active-low.
- `det_data_in`  out  1  serial bit to the detector.
- `det_data_out`  in  1  detector match flag; registered, valid the cycle after the completing bit.
- `resp_valid`  out  1  response available.
- `resp_id`  out  1  requester that owns the response.
- `resp_count`  out  CNT_W  number of matches in the word.
- `resp_ready`  in  1  consumer accepts the response.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, SHIFT, DRAIN, RESP.
- IDLE:
  - `det_rst_n`=0, `det_data_in`=0.
  - Arbitrate among the valid requesters: a single valid requester wins; if both are valid, the requester ≠ `last_grant` wins.
  - The winner's `ready`=1 combinationally, for that cycle only.
  - On the handshake: latch data into the shift register, latch `id`, set `last_grant`=`id`, clear the count and bit counter, go to SHIFT.
- SHIFT (WIDTH cycles, k = 0..WIDTH−1):
  - `det_rst_n`=1, `det_data_in` = shift register MSB, shift left each cycle.
  - On k ≥ 1, sample `det_data_out`; if 1, increment the count (saturating).
  - After k = WIDTH−1, go to DRAIN.
- DRAIN (1 cycle):
  - `det_rst_n`=1, `det_data_in`=0; this filler bit is discarded.
  - Sample `det_data_out` (the flag for the last real bit) and count it as in SHIFT.
  - Go to RESP.
- RESP:
  - `det_rst_n`=0, `resp_valid`=1; `resp_id` and `resp_count` are stable.
  - Stay in RESP until `resp_ready`=1, then go to IDLE.
  - Both `ready` outputs are 0 in RESP.
- Exactly WIDTH samples are taken per word. The detector flag seen in SHIFT k=0 is ignored; it is a post-reset value.
- Matches never span words; a reset cycle always separates words.

## Timing
- Reset values: state IDLE, `last_grant`=1 (req0 wins the first tie), count 0, and these outputs:
  - `det_rst_n`=0, `det_data_in`=0.
  - `resp_valid`=0, `resp_id`=0, `resp_count`=0.
  - `busy`=0, `req0_ready`=0, `req1_ready`=0.
- Handshake in cycle T:
  - bit WIDTH−1−k on `det_data_in` in cycle T+1+k;
  - DRAIN at T+WIDTH+1;
  - `resp_valid` first high at T+WIDTH+2.
- Minimum word-to-word period is WIDTH+3 cycles: the response is accepted in its first cycle and the next word is accepted in IDLE the cycle after.
- `det_rst_n` is low for at least 2 consecutive cycles between words (RESP + IDLE).
- `rst` mid-word (SHIFT, DRAIN or RESP): back to reset values next cycle. The in-flight word is dropped and no response is issued.
- A requester dropping `valid` without a handshake has no effect.
- `resp_ready` outside RESP is ignored.

## Test plan
The bench detector model is overlapping Moore detection of 1011 with a registered flag.

- After reset, req0 only with `8'b1011_1011` → `req0_ready` high one cycle; `det_data_in` = 1,0,1,1,1,0,1,1; `resp_id`=0, `resp_count`=2, `resp_valid` 10 cycles after the handshake.
- req1 only with `8'b1011_0110` (overlapping match) → `resp_id`=1, `resp_count`=2.
- Tie case: req0 and req1 both valid continuously after reset, with `resp_ready`=1 → grants alternate 0,1,0,1; each word takes 11 cycles.
- Boundary case:
  - stimulus: req0 sends `8'b0000_0101`, then `8'b1000_0000`;
  - required: both counts are 0, with no cross-word match;
  - also check `det_rst_n` is 0 between the two words.
- Saturation and stall:
  - stimulus: `CNT_W`=1, `WIDTH`=8, word `8'b1011_1011`, with `resp_ready` held low 5 cycles;
  - required: `resp_count`=1;
  - required: `resp_valid` and the response fields stay stable throughout the stall;
  - required: both `ready` outputs stay 0 throughout the stall.
- `rst` pulsed in SHIFT k=4 → next cycle all outputs at reset values, no `resp_valid`; a following word is processed normally.

Source files
------------

// File: rtl/seq_detect_sched.sv
// Round-robin front end that shares one serial 1-bit sequence detector between two
// word requesters, shifting each word MSB-first and returning its saturated match count.
module seq_detect_sched #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    output logic             det_rst_n,
    output logic             det_data_in,
    input  logic             det_data_out,
    output logic             resp_valid,
    output logic             resp_id,
    output logic [CNT_W-1:0] resp_count,
    input  logic             resp_ready,
    output logic             busy
);
    localparam int               BIT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DRAIN,
        RESP
    } state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] shift_reg;
    logic [BIT_W-1:0] bit_cnt;
    logic [CNT_W-1:0] count;
    logic             id;
    logic             last_grant;

    logic grant0;
    logic grant1;
    logic take;
    logic sample;

    // last_grant = 1 means req1 was served last, so req0 wins the next tie.
    always_comb begin
        grant0 = req0_valid && (!req1_valid || last_grant);
        grant1 = req1_valid && (!req0_valid || !last_grant);
        take   = (state == IDLE) && (grant0 || grant1);
        // The flag seen in the first SHIFT cycle is the post-reset value, not a result.
        sample = ((state == SHIFT) && (bit_cnt != '0)) || (state == DRAIN);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:  if (take) state_next = SHIFT;
            SHIFT: if (bit_cnt == LAST_BIT) state_next = DRAIN;
            DRAIN: state_next = RESP;
            RESP:  if (resp_ready) state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_reg  <= '0;
            bit_cnt    <= '0;
            count      <= '0;
            id         <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            if (take) begin
                shift_reg  <= grant1 ? req1_data : req0_data;
                bit_cnt    <= '0;
                count      <= '0;
                id         <= grant1;
                last_grant <= grant1;
            end
            if (state == SHIFT) begin
                shift_reg <= {shift_reg[WIDTH-2:0], 1'b0};
                bit_cnt   <= bit_cnt + 1'b1;
            end
            if (sample && det_data_out && (count != CNT_MAX)) begin
                count <= count + 1'b1;
            end
        end
    end

    // The detector is held in reset outside SHIFT/DRAIN so words never share a match.
    always_comb begin
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        det_rst_n   = 1'b0;
        det_data_in = 1'b0;
        resp_valid  = 1'b0;
        busy        = (state != IDLE);
        unique case (state)
            IDLE: begin
                req0_ready = grant0;
                req1_ready = grant1;
            end
            SHIFT: begin
                det_rst_n   = 1'b1;
                det_data_in = shift_reg[WIDTH-1];
            end
            DRAIN: det_rst_n = 1'b1;
            RESP:  resp_valid = 1'b1;
        endcase
    end

    assign resp_id    = id;
    assign resp_count = count;

endmodule

// File: tb/tb_seq_detect_sched.sv
// Bench for seq_detect_sched: two instances (CNT_W=4 and CNT_W=1) share stimulus, each
// driving its own overlapping Moore 1011 detector model with a registered flag.
module tb_seq_detect_sched;
    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             req0_valid;
    logic             req1_valid;
    logic [WIDTH-1:0] req0_data;
    logic [WIDTH-1:0] req1_data;
    logic             resp_ready;

    logic req0_ready   [2];
    logic req1_ready   [2];
    logic det_rst_n    [2];
    logic det_data_in  [2];
    logic det_data_out [2];
    logic resp_valid   [2];
    logic resp_id      [2];
    logic busy         [2];
    logic [3:0] count_a;
    logic [0:0] count_b;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int hs_cyc = 0;
    bit hs_valid = 1'b0;

    typedef struct {
        bit             v0;
        bit             v1;
        logic [WIDTH-1:0] d0;
        logic [WIDTH-1:0] d1;
        int             stall;
        bit             hold;
        bit             exp_id;
        int             exp_cnt;
    } vec_t;

    typedef struct {
        bit id;
        int cnt;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[11];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    seq_detect_sched #(.WIDTH(WIDTH), .CNT_W(4)) dut_a (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready[0]),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready[0]),
        .det_rst_n(det_rst_n[0]), .det_data_in(det_data_in[0]), .det_data_out(det_data_out[0]),
        .resp_valid(resp_valid[0]), .resp_id(resp_id[0]), .resp_count(count_a),
        .resp_ready(resp_ready), .busy(busy[0])
    );

    seq_detect_sched #(.WIDTH(WIDTH), .CNT_W(1)) dut_b (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready[1]),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready[1]),
        .det_rst_n(det_rst_n[1]), .det_data_in(det_data_in[1]), .det_data_out(det_data_out[1]),
        .resp_valid(resp_valid[1]), .resp_id(resp_id[1]), .resp_count(count_b),
        .resp_ready(resp_ready), .busy(busy[1])
    );

    // Overlapping Moore detector for 1011, synchronous active-low reset, registered flag.
    for (genvar g = 0; g < 2; g++) begin : g_det
        logic [2:0] hist;
        always @(posedge clk) begin
            if (!det_rst_n[g]) begin
                hist            <= '0;
                det_data_out[g] <= 1'b0;
            end else begin
                hist            <= {hist[1:0], det_data_in[g]};
                det_data_out[g] <= ({hist, det_data_in[g]} == 4'b1011);
            end
        end
    end

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_val(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int i = 0; i < 2; i++) begin
            check_bit({tag, "_det_rst_n"}, det_rst_n[i], 1'b0);
            check_bit({tag, "_det_data_in"}, det_data_in[i], 1'b0);
            check_bit({tag, "_resp_valid"}, resp_valid[i], 1'b0);
            check_bit({tag, "_resp_id"}, resp_id[i], 1'b0);
            check_bit({tag, "_busy"}, busy[i], 1'b0);
            check_bit({tag, "_req0_ready"}, req0_ready[i], 1'b0);
            check_bit({tag, "_req1_ready"}, req1_ready[i], 1'b0);
        end
        check_val({tag, "_count_a"}, int'(count_a), 0);
        check_val({tag, "_count_b"}, int'(count_b), 0);
    endtask

    // Drives one word from handshake to response acceptance; returns in the following IDLE cycle.
    task automatic run_word(input vec_t v);
        exp_t             e;
        logic [WIDTH-1:0] word;
        int               waited;
        int               sat;

        req0_valid = v.v0;
        req1_valid = v.v1;
        req0_data  = v.d0;
        req1_data  = v.d1;
        #1;
        waited = 0;
        while (!(req0_ready[0] || req1_ready[0]) && waited < 4) begin
            step();
            #1;
            waited++;
        end
        if (!(req0_ready[0] || req1_ready[0])) begin
            checks++;
            errors++;
            $display("FAIL handshake: no ready after %0d cycles, required within 4", waited);
            req0_valid = 1'b0;
            req1_valid = 1'b0;
            return;
        end

        for (int i = 0; i < 2; i++) begin
            check_bit("grant_req0_ready", req0_ready[i], !v.exp_id);
            check_bit("grant_req1_ready", req1_ready[i], v.exp_id);
            check_bit("idle_det_rst_n", det_rst_n[i], 1'b0);
        end
        word     = v.exp_id ? v.d1 : v.d0;
        e.id     = v.exp_id;
        e.cnt    = v.exp_cnt;
        sb.push_back(e);
        if (v.hold && hs_valid) check_val("word_period", cyc - hs_cyc, WIDTH + 3);
        hs_cyc   = cyc;
        hs_valid = v.hold;

        step();
        if (!v.hold) begin
            req0_valid = 1'b0;
            req1_valid = 1'b0;
        end
        #1;
        for (int k = 0; k < WIDTH; k++) begin
            if (k > 0) begin
                step();
                #1;
            end
            for (int i = 0; i < 2; i++) begin
                check_bit($sformatf("shift_bit%0d", k), det_data_in[i], word[WIDTH-1-k]);
                check_bit("shift_det_rst_n", det_rst_n[i], 1'b1);
                check_bit("shift_ready", req0_ready[i] | req1_ready[i], 1'b0);
                check_bit("shift_busy", busy[i], 1'b1);
            end
        end

        step();
        #1;
        for (int i = 0; i < 2; i++) begin
            check_bit("drain_det_data_in", det_data_in[i], 1'b0);
            check_bit("drain_det_rst_n", det_rst_n[i], 1'b1);
            check_bit("drain_resp_valid", resp_valid[i], 1'b0);
        end

        step();
        #1;
        e   = sb.pop_front();
        sat = (e.cnt > 1) ? 1 : e.cnt;
        for (int s = 0; s <= v.stall; s++) begin
            if (s > 0) begin
                step();
                #1;
            end
            for (int i = 0; i < 2; i++) begin
                check_bit("resp_valid", resp_valid[i], 1'b1);
                check_bit("resp_id", resp_id[i], e.id);
                check_bit("resp_ready_outs", req0_ready[i] | req1_ready[i], 1'b0);
                check_bit("resp_det_rst_n", det_rst_n[i], 1'b0);
            end
            check_val("resp_count_a", int'(count_a), e.cnt);
            check_val("resp_count_b_sat", int'(count_b), sat);
            if (s == v.stall) resp_ready = 1'b1;
        end

        step();
        resp_ready = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            check_bit("post_resp_valid", resp_valid[i], 1'b0);
            check_bit("post_busy", busy[i], 1'b0);
            check_bit("post_det_rst_n", det_rst_n[i], 1'b0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t post_rst;

        tbl[0]  = '{1'b1, 1'b0, 8'hBB, 8'h00, 0, 1'b0, 1'b0, 2};
        tbl[1]  = '{1'b0, 1'b1, 8'h00, 8'hB6, 0, 1'b0, 1'b1, 2};
        tbl[2]  = '{1'b1, 1'b0, 8'h05, 8'h00, 0, 1'b0, 1'b0, 0};
        tbl[3]  = '{1'b1, 1'b0, 8'h80, 8'h00, 0, 1'b0, 1'b0, 0};
        tbl[4]  = '{1'b1, 1'b0, 8'hBB, 8'h00, 5, 1'b0, 1'b0, 2};
        tbl[5]  = '{1'b0, 1'b1, 8'h00, 8'h2D, 0, 1'b0, 1'b1, 1};
        tbl[6]  = '{1'b1, 1'b1, 8'hBB, 8'hB6, 0, 1'b1, 1'b0, 2};
        tbl[7]  = '{1'b1, 1'b1, 8'hBB, 8'hB6, 0, 1'b1, 1'b1, 2};
        tbl[8]  = '{1'b1, 1'b1, 8'hBB, 8'hB6, 0, 1'b1, 1'b0, 2};
        tbl[9]  = '{1'b1, 1'b1, 8'hBB, 8'hB6, 0, 1'b1, 1'b1, 2};
        tbl[10] = '{1'b1, 1'b1, 8'h2D, 8'hBB, 0, 1'b0, 1'b0, 1};

        rst        = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_data  = '0;
        req1_data  = '0;
        resp_ready = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        #1;
        check_reset_outputs("reset");

        for (int n = 0; n < 6; n++) run_word(tbl[n]);

        // Ties right after reset must alternate starting with req0.
        rst = 1'b1;
        step();
        rst = 1'b0;
        hs_valid = 1'b0;
        for (int n = 6; n < 10; n++) run_word(tbl[n]);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        step();

        // Reset pulse during SHIFT k=4 drops the in-flight word.
        req1_valid = 1'b1;
        req1_data  = 8'hBB;
        #1;
        check_bit("midrst_grant", req1_ready[0], 1'b1);
        step();
        req1_valid = 1'b0;
        repeat (4) step();
        check_bit("midrst_in_shift", det_rst_n[0], 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check_reset_outputs("midrst");
        for (int c = 0; c < WIDTH + 4; c++) begin
            step();
            check_bit("midrst_no_resp", resp_valid[0] | resp_valid[1], 1'b0);
        end

        post_rst = tbl[10];
        run_word(post_rst);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
